// File: rtl/amp_safety_supervisor.sv
// N-axis amplifier-enable supervisor: per-axis disable state, power/relay control,
// prescaled watchdog with sticky timeout, motor-voltage settle timer and cause latches.
module amp_safety_supervisor #(
  parameter int NUM_AXES     = 4,
  parameter int WDOG_PRESC_W = 8,
  parameter int WDOG_W       = 16,
  parameter int MV_SETTLE    = 7680
) (
  input  logic                sysclk,
  input  logic                reset,
  input  logic [3:0]          reg_addr,
  input  logic [31:0]         reg_wdata,
  input  logic                wr_en,
  output logic [31:0]         reg_rdata,
  input  logic [NUM_AXES-1:0] safety_disable,
  input  logic                mv_good,
  output logic [NUM_AXES-1:0] amp_disable,
  output logic                pwr_enable,
  output logic                relay_on,
  output logic                wdog_timeout
);

  localparam int              MV_W    = $clog2(MV_SETTLE + 1);
  localparam logic [MV_W-1:0] MV_DONE = MV_W'(MV_SETTLE);

  typedef enum logic [3:0] {
    ADDR_CTRL   = 4'd0,
    ADDR_PERIOD = 4'd1,
    ADDR_CAUSE  = 4'd2
  } reg_addr_e;

  logic [WDOG_PRESC_W-1:0] presc;
  logic [WDOG_W-1:0]       wdog_period, wdog_count;
  logic [MV_W-1:0]         mv_count;
  logic [NUM_AXES-1:0]     reg_disable, wdog_cause, safety_cause, mv_cause;
  logic [NUM_AXES-1:0]     disable_nxt, wdog_cause_nxt, safety_cause_nxt, mv_cause_nxt;
  logic [NUM_AXES-1:0]     axis_mask, axis_enable;
  logic                    tick, wr_ctrl, wr_period, wdog_step, wdog_expire, mv_block;
  logic [31:0]             rdata_nxt;
  logic                    unused_wdata;

  assign unused_wdata = ^reg_wdata;

  // A write restarts the prescaler, so a write cycle never produces a tick.
  assign tick      = (&presc) && !wr_en;
  assign wr_ctrl   = wr_en && (reg_addr == ADDR_CTRL);
  assign wr_period = wr_en && (reg_addr == ADDR_PERIOD);

  assign axis_mask   = wr_ctrl ? reg_wdata[8 +: NUM_AXES] : '0;
  assign axis_enable = axis_mask & reg_wdata[NUM_AXES-1:0];

  assign wdog_step   = tick && (wdog_period != '0) && (wdog_count < wdog_period);
  assign wdog_expire = wdog_step && ((wdog_count + WDOG_W'(1)) == wdog_period);

  assign mv_block    = (mv_count != MV_DONE);
  assign amp_disable = reg_disable | {NUM_AXES{mv_block}};

  // Safety is OR-ed in last so it beats a same-cycle enable write.
  assign disable_nxt = (wdog_expire ? {NUM_AXES{1'b1}}
                                    : ((reg_disable & ~axis_mask) | (axis_mask & ~reg_wdata[NUM_AXES-1:0])))
                       | safety_disable;

  assign wdog_cause_nxt   = (wdog_cause & ~axis_mask) | (wdog_expire ? ~reg_disable : '0);
  assign safety_cause_nxt = (safety_cause & ~axis_mask) | (safety_disable & (~reg_disable | axis_enable));
  assign mv_cause_nxt     = (mv_cause & ~axis_mask) | (mv_good ? '0 : ~reg_disable);

  always_comb begin
    // NOTE: default assigned first so no address path can infer a latch.
    rdata_nxt = '0;
    case (reg_addr)
      ADDR_CTRL: begin
        rdata_nxt[31:28]          = 4'(NUM_AXES);
        rdata_nxt[23]             = wdog_timeout;
        rdata_nxt[20]             = mv_good;
        rdata_nxt[19]             = mv_block;
        rdata_nxt[18]             = pwr_enable;
        rdata_nxt[16]             = relay_on;
        rdata_nxt[NUM_AXES-1:0]   = ~amp_disable;
      end
      ADDR_PERIOD: rdata_nxt[WDOG_W-1:0] = wdog_period;
      ADDR_CAUSE: begin
        rdata_nxt[16 +: NUM_AXES] = mv_cause;
        rdata_nxt[8 +: NUM_AXES]  = safety_cause;
        rdata_nxt[0 +: NUM_AXES]  = wdog_cause;
      end
      default: rdata_nxt = '0;
    endcase
  end

  // NOTE: every state register uses non-blocking assignment so all updates see pre-edge values.
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      reg_disable  <= '1;
      pwr_enable   <= 1'b0;
      relay_on     <= 1'b0;
      wdog_timeout <= 1'b0;
      reg_rdata    <= '0;
      wdog_period  <= '0;
      wdog_count   <= '0;
      presc        <= '0;
      mv_count     <= '0;
      wdog_cause   <= '0;
      safety_cause <= '0;
      mv_cause     <= '0;
    end else begin
      reg_disable  <= disable_nxt;
      wdog_cause   <= wdog_cause_nxt;
      safety_cause <= safety_cause_nxt;
      mv_cause     <= mv_cause_nxt;
      reg_rdata    <= rdata_nxt;
      presc        <= wr_en ? '0 : presc + 1'b1;

      if (wr_en)          wdog_count <= '0;
      else if (wdog_step) wdog_count <= wdog_count + WDOG_W'(1);

      if (wr_period) wdog_period <= reg_wdata[WDOG_W-1:0];

      if (wr_ctrl && reg_wdata[20]) wdog_timeout <= 1'b0;
      else if (wdog_expire)         wdog_timeout <= 1'b1;

      if (wr_ctrl && reg_wdata[17]) relay_on   <= reg_wdata[16];
      if (wr_ctrl && reg_wdata[19]) pwr_enable <= reg_wdata[18];

      if (!mv_good)                       mv_count <= '0;
      else if (tick && mv_count < MV_DONE) mv_count <= mv_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_amp_safety_supervisor.sv
// Self-checking bench for amp_safety_supervisor: small timer parameters, a behavioural
// register/timer model, directed scenarios and a randomized phase compared every cycle.
module tb_amp_safety_supervisor;

  localparam int NA      = 4;
  localparam int PW      = 2;
  localparam int MVS     = 6;
  localparam int PRESC_N = 1 << PW;

  logic        sysclk = 1'b0;
  logic        reset  = 1'b0;
  logic [3:0]  reg_addr = '0;
  logic [31:0] reg_wdata = '0;
  logic        wr_en = 1'b0;
  logic [31:0] reg_rdata;
  logic [NA-1:0] safety_disable = '0;
  logic        mv_good = 1'b1;
  logic [NA-1:0] amp_disable;
  logic        pwr_enable, relay_on, wdog_timeout;

  logic [3:0]  addr8 = '0;
  logic [31:0] wdata8 = '0;
  logic        wr8 = 1'b0;
  logic [31:0] rdata8;
  logic [7:0]  safety8 = '0;
  logic        mv_good8 = 1'b1;
  logic [7:0]  amp8;
  logic        pwr8, relay8, to8;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 sysclk = ~sysclk;

  amp_safety_supervisor #(.NUM_AXES(NA), .WDOG_PRESC_W(PW), .WDOG_W(16), .MV_SETTLE(MVS)) u_dut (
    .sysclk(sysclk), .reset(reset), .reg_addr(reg_addr), .reg_wdata(reg_wdata), .wr_en(wr_en),
    .reg_rdata(reg_rdata), .safety_disable(safety_disable), .mv_good(mv_good),
    .amp_disable(amp_disable), .pwr_enable(pwr_enable), .relay_on(relay_on),
    .wdog_timeout(wdog_timeout)
  );

  amp_safety_supervisor #(.NUM_AXES(8), .WDOG_PRESC_W(PW), .WDOG_W(16), .MV_SETTLE(MVS)) u_dut8 (
    .sysclk(sysclk), .reset(reset), .reg_addr(addr8), .reg_wdata(wdata8), .wr_en(wr8),
    .reg_rdata(rdata8), .safety_disable(safety8), .mv_good(mv_good8),
    .amp_disable(amp8), .pwr_enable(pwr8), .relay_on(relay8), .wdog_timeout(to8)
  );

  // Behavioural model: integer timers, per-axis flags, evaluated from pre-edge state.
  bit [NA-1:0] m_dis, m_wc, m_sc, m_mc;
  bit          m_pwr, m_relay, m_to;
  int          m_period, m_wcnt, m_presc, m_mvcnt;
  bit [31:0]   m_rdata;
  bit          t_tick;
  bit [NA-1:0] t_old, t_amp, t_inv;

  function automatic bit [NA-1:0] model_amp();
    return m_dis | ((m_mvcnt < MVS) ? {NA{1'b1}} : {NA{1'b0}});
  endfunction

  function automatic logic [38:0] exp_vec();
    return {model_amp(), m_pwr, m_relay, m_to, m_rdata};
  endfunction

  always @(posedge sysclk) begin
    if (!reset) begin
      m_dis = '1; m_pwr = 0; m_relay = 0; m_to = 0; m_rdata = 0;
      m_period = 0; m_wcnt = 0; m_presc = 0; m_mvcnt = 0;
      m_wc = 0; m_sc = 0; m_mc = 0;
    end else begin
      t_tick = (m_presc == PRESC_N - 1) && !wr_en;
      t_old  = m_dis;
      t_amp  = model_amp();
      t_inv  = ~t_amp;
      case (reg_addr)
        4'd0: m_rdata = 32'h4000_0000 | (32'(m_to) << 23) | (32'(mv_good) << 20)
                      | (32'(m_mvcnt < MVS) << 19) | (32'(m_pwr) << 18) | (32'(m_relay) << 16)
                      | 32'(t_inv);
        4'd1: m_rdata = 32'(m_period);
        4'd2: m_rdata = (32'(m_mc) << 16) | (32'(m_sc) << 8) | 32'(m_wc);
        default: m_rdata = 0;
      endcase
      if (wr_en) begin
        m_presc = 0;
        m_wcnt  = 0;
        if (reg_addr == 4'd1) m_period = int'(reg_wdata[15:0]);
        if (reg_addr == 4'd0) begin
          for (int i = 0; i < NA; i++)
            if (reg_wdata[8+i]) begin
              m_dis[i] = !reg_wdata[i];
              m_wc[i] = 0; m_sc[i] = 0; m_mc[i] = 0;
            end
          if (reg_wdata[17]) m_relay = reg_wdata[16];
          if (reg_wdata[19]) m_pwr   = reg_wdata[18];
          if (reg_wdata[20]) m_to    = 0;
        end
      end else begin
        m_presc = (m_presc + 1) % PRESC_N;
        if (t_tick && m_period != 0 && m_wcnt < m_period) begin
          m_wcnt++;
          if (m_wcnt == m_period) begin
            m_to = 1;
            m_wc = m_wc | ~t_old;
            m_dis = '1;
          end
        end
      end
      if (!mv_good) begin
        m_mvcnt = 0;
        m_mc = m_mc | ~t_old;
      end else if (t_tick && m_mvcnt < MVS) m_mvcnt++;
      for (int i = 0; i < NA; i++)
        if (safety_disable[i]) begin
          if (!t_old[i] || !m_dis[i]) m_sc[i] = 1;
          m_dis[i] = 1;
        end
    end
  end

  task automatic do_write(input logic [3:0] a, input logic [31:0] d);
    reg_addr = a; reg_wdata = d; wr_en = 1'b1;
    @(negedge sysclk);
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; mv_good = 1'b1;
    repeat (3) @(negedge sysclk);
    n_checks++;
    if (amp_disable !== 4'hF || pwr_enable !== 1'b0 || relay_on !== 1'b0 || wdog_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got amp=%h pwr=%b relay=%b to=%b, need amp=f pwr=0 relay=0 to=0",
               amp_disable, pwr_enable, relay_on, wdog_timeout);
    end
    n_checks++;
    if (reg_rdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_rdata: got %h need 00000000", reg_rdata);
    end
    reset = 1'b1;
    @(negedge sysclk);
    n_checks++;
    if (reg_rdata !== 32'h4018_0000) begin
      n_fail++; $display("FAIL reset_addr0_read: got %h need 40180000", reg_rdata);
    end
  endtask

  task automatic test_mv_settle();
    do_write(4'd0, 32'h000C_0F0F);
    n_checks++;
    if (pwr_enable !== 1'b1 || amp_disable !== 4'hF) begin
      n_fail++; $display("FAIL mv_blocked: got pwr=%b amp=%h need pwr=1 amp=f", pwr_enable, amp_disable);
    end
    for (int c = 0; c < 40; c++) begin
      @(negedge sysclk);
      n_checks++;
      if ({amp_disable, pwr_enable, relay_on, wdog_timeout, reg_rdata} !== exp_vec()) begin
        n_fail++;
        $display("FAIL mv_settle_model c=%0d: got %h need %h", c,
                 {amp_disable, pwr_enable, relay_on, wdog_timeout, reg_rdata}, exp_vec());
      end
    end
    n_checks++;
    if (amp_disable !== 4'h0) begin
      n_fail++; $display("FAIL mv_settled: got amp=%h need 0", amp_disable);
    end
    mv_good = 1'b0;
    repeat (2) @(negedge sysclk);
    n_checks++;
    if (amp_disable !== 4'hF) begin
      n_fail++; $display("FAIL mv_drop: got amp=%h need f", amp_disable);
    end
    reg_addr = 4'd2;
    @(negedge sysclk);
    n_checks++;
    if (reg_rdata[23:16] !== 8'h0F) begin
      n_fail++; $display("FAIL mv_cause: got %h need 0f", reg_rdata[23:16]);
    end
    mv_good = 1'b1;
    reg_addr = 4'd0;
    repeat (30) @(negedge sysclk);
    n_checks++;
    if ({amp_disable, pwr_enable, relay_on, wdog_timeout, reg_rdata} !== exp_vec() || amp_disable !== 4'h0) begin
      n_fail++;
      $display("FAIL mv_resettle: got %h need %h", {amp_disable, pwr_enable, relay_on, wdog_timeout, reg_rdata},
               exp_vec());
    end
  endtask

  task automatic test_watchdog();
    do_write(4'd1, 32'd3);
    for (int c = 0; c < 20; c++) begin
      @(negedge sysclk);
      n_checks++;
      if ({amp_disable, pwr_enable, relay_on, wdog_timeout, reg_rdata} !== exp_vec()) begin
        n_fail++;
        $display("FAIL wdog_model c=%0d: got %h need %h", c,
                 {amp_disable, pwr_enable, relay_on, wdog_timeout, reg_rdata}, exp_vec());
      end
    end
    n_checks++;
    if (wdog_timeout !== 1'b1 || amp_disable !== 4'hF) begin
      n_fail++; $display("FAIL wdog_expire: got to=%b amp=%h need to=1 amp=f", wdog_timeout, amp_disable);
    end
    reg_addr = 4'd2;
    @(negedge sysclk);
    n_checks++;
    if (reg_rdata[7:0] !== 8'h0F) begin
      n_fail++; $display("FAIL wdog_cause: got %h need 0f", reg_rdata[7:0]);
    end
    do_write(4'd0, 32'h0000_0F0F);
    n_checks++;
    if (amp_disable !== 4'h0 || wdog_timeout !== 1'b1) begin
      n_fail++; $display("FAIL wdog_sticky: got amp=%h to=%b need amp=0 to=1", amp_disable, wdog_timeout);
    end
    do_write(4'd0, 32'h0010_0000);
    n_checks++;
    if (wdog_timeout !== 1'b0) begin
      n_fail++; $display("FAIL wdog_clear: got to=%b need 0", wdog_timeout);
    end
    do_write(4'd1, 32'd0);
  endtask

  task automatic test_kick();
    do_write(4'd0, 32'h0000_0F0F);
    do_write(4'd1, 32'd3);
    for (int k = 0; k < 8; k++) begin
      for (int c = 0; c < 9; c++) begin
        @(negedge sysclk);
        n_checks++;
        if ({amp_disable, pwr_enable, relay_on, wdog_timeout, reg_rdata} !== exp_vec() || wdog_timeout !== 1'b0) begin
          n_fail++;
          $display("FAIL kick_model k=%0d: got %h need %h", k,
                   {amp_disable, pwr_enable, relay_on, wdog_timeout, reg_rdata}, exp_vec());
        end
      end
      do_write(4'd5, $urandom);
    end
    // The write below lands exactly on the edge carrying the third tick.
    repeat (11) @(negedge sysclk);
    do_write(4'd7, 32'h0);
    repeat (4) @(negedge sysclk);
    n_checks++;
    if (wdog_timeout !== 1'b0 || amp_disable !== 4'h0) begin
      n_fail++; $display("FAIL kick_on_expiry: got to=%b amp=%h need to=0 amp=0", wdog_timeout, amp_disable);
    end
    do_write(4'd1, 32'd0);
  endtask

  task automatic test_safety();
    safety_disable = 4'b0100;
    @(negedge sysclk);
    safety_disable = 4'b0000;
    n_checks++;
    if (amp_disable !== 4'b0100) begin
      n_fail++; $display("FAIL safety_latch: got amp=%h need 4", amp_disable);
    end
    reg_addr = 4'd2;
    @(negedge sysclk);
    n_checks++;
    if (reg_rdata[15:8] !== 8'h04) begin
      n_fail++; $display("FAIL safety_cause: got %h need 04", reg_rdata[15:8]);
    end
    safety_disable = 4'b0100;
    do_write(4'd0, 32'h0000_0404);
    n_checks++;
    if (amp_disable[2] !== 1'b1) begin
      n_fail++; $display("FAIL safety_override: got amp[2]=%b need 1", amp_disable[2]);
    end
    safety_disable = 4'b0000;
    reg_addr = 4'd2;
    repeat (2) @(negedge sysclk);
    n_checks++;
    if ({amp_disable, pwr_enable, relay_on, wdog_timeout, reg_rdata} !== exp_vec() || reg_rdata[10] !== 1'b1) begin
      n_fail++;
      $display("FAIL safety_model: got %h need %h", {amp_disable, pwr_enable, relay_on, wdog_timeout, reg_rdata},
               exp_vec());
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      n_checks++;
      if ({amp_disable, pwr_enable, relay_on, wdog_timeout, reg_rdata} !== exp_vec()) begin
        n_fail++;
        $display("FAIL random_model c=%0d: got %h need %h", c,
                 {amp_disable, pwr_enable, relay_on, wdog_timeout, reg_rdata}, exp_vec());
      end
      reset          = ($urandom_range(0, 299) != 0);
      wr_en          = ($urandom_range(0, 7) == 0);
      reg_addr       = 4'($urandom_range(0, 5));
      reg_wdata      = (reg_addr == 4'd1) ? 32'($urandom_range(0, 4)) : $urandom;
      safety_disable = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'h0;
      mv_good        = ($urandom_range(0, 63) != 0);
      @(negedge sysclk);
    end
    reset = 1'b1; wr_en = 1'b0; safety_disable = '0; mv_good = 1'b1;
    @(negedge sysclk);
  endtask

  task automatic test_eight_axes();
    wdata8 = 32'h0000_FFFF; addr8 = 4'd0; wr8 = 1'b1;
    @(negedge sysclk);
    wr8 = 1'b0;
    repeat (40) @(negedge sysclk);
    n_checks++;
    if (amp8 !== 8'h00 || rdata8[31:28] !== 4'd8 || rdata8[7:0] !== 8'hFF) begin
      n_fail++;
      $display("FAIL eight_axes: got amp=%h rdata=%h need amp=00 rdata[31:28]=8 rdata[7:0]=ff", amp8, rdata8);
    end
  endtask

  initial begin
    test_reset();
    test_mv_settle();
    test_watchdog();
    test_kick();
    test_safety();
    test_random();
    test_eight_axes();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
